// File: rtl/st_pkg.sv
// Shared types and helpers for the Avalon-ST width converters.
package st_pkg;

  typedef enum logic {
    IDLE,
    PKT
  } st_state_e;

  localparam int SAT_W = 16;

  // Lane 0 is the most-significant lane of the wide word.
  function automatic int lane_lsb(input int out_w, input int in_w, input int idx);
    return out_w - (idx + 1) * in_w;
  endfunction

  function automatic int fill_empty(input int ratio, input int in_syms, input int idx);
    return (ratio - 1 - idx) * in_syms;
  endfunction

  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/st_out_reg.sv
// Single-slot registered Avalon-ST source stage; holds data stable until out_ready.
module st_out_reg #(
  parameter int W       = 32,
  parameter int EMPTY_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [W-1:0]       d_data,
  input  logic               d_sop,
  input  logic               d_eop,
  input  logic [EMPTY_W-1:0] d_empty,
  output logic               free,
  output logic [W-1:0]       out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sop,
  output logic               out_eop,
  output logic [EMPTY_W-1:0] out_empty
);

  // The caller only loads when free, so a load never overwrites a pending beat.
  assign free = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_empty <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= d_data;
      out_sop   <= d_sop;
      out_eop   <= d_eop;
      out_empty <= d_empty;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/st_width_upsizer.sv
// Avalon-ST width upsizer: packs RATIO narrow beats into one wide beat, MS lane first.
// Optional ST_UPSIZE_PKTLEN_EN adds a pkt_len port with the last packet's narrow-beat count.
module st_width_upsizer
  import st_pkg::*;
#(
  parameter int SYM_W       = 8,
  parameter int IN_SYMS     = 2,
  parameter int RATIO       = 2,
  parameter int IN_EMPTY_W  = 1,
  parameter int OUT_EMPTY_W = 2,
  localparam int IN_W       = SYM_W * IN_SYMS,
  localparam int OUT_W      = IN_W * RATIO
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IN_W-1:0]        in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sop,
  input  logic                   in_eop,
  input  logic [IN_EMPTY_W-1:0]  in_empty,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sop,
  output logic                   out_eop,
  output logic [OUT_EMPTY_W-1:0] out_empty,
  output logic [15:0]            drop_cnt
`ifdef ST_UPSIZE_PKTLEN_EN
  , output logic [15:0]          pkt_len
`endif
);

  // state | meaning
  // IDLE  | outside a packet; sop beat opens at lane 0, other beats are dropped
  // PKT   | inside a packet; beats fill consecutive lanes until RATIO or eop

  localparam int IDX_W = $clog2(RATIO);

  st_state_e               state_q, state_d;
  logic [IDX_W-1:0]        idx_q;
  logic [IN_W-1:0]         acc_q [RATIO-1];
  logic                    sop_pend_q;
  logic [SAT_W-1:0]        drop_cnt_q;
  logic                    closing, xfer, free;
  logic                    accept, load, drop, wide_sop;
  logic [OUT_W-1:0]        wide;
  logic [OUT_EMPTY_W-1:0]  wide_empty;

  assign closing  = (idx_q == IDX_W'(RATIO - 1)) || in_eop;
  assign in_ready = free || !closing;
  assign xfer     = in_valid && in_ready;
  assign drop_cnt = drop_cnt_q;

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    load     = 1'b0;
    drop     = 1'b0;
    wide_sop = sop_pend_q;
    case (state_q)
      IDLE: begin
        wide_sop = 1'b1;
        if (xfer) begin
          if (in_sop) begin
            accept = 1'b1;
            load   = in_eop;
            if (!in_eop) state_d = PKT;
          end else begin
            drop = 1'b1;
          end
        end
      end
      PKT: begin
        if (xfer) begin
          accept = 1'b1;
          load   = closing;
          if (in_eop) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Lanes past the current index are left zero.
  always_comb begin
    wide = '0;
    for (int i = 0; i < RATIO - 1; i++) begin
      if (i < int'(idx_q)) wide[lane_lsb(OUT_W, IN_W, i) +: IN_W] = acc_q[i];
    end
    wide[lane_lsb(OUT_W, IN_W, int'(idx_q)) +: IN_W] = in_data;
  end

  assign wide_empty = OUT_EMPTY_W'(fill_empty(RATIO, IN_SYMS, int'(idx_q))
                                   + (in_eop ? int'(in_empty) : 0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      sop_pend_q <= 1'b0;
      drop_cnt_q <= '0;
      for (int i = 0; i < RATIO - 1; i++) acc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (drop) drop_cnt_q <= sat_inc(drop_cnt_q);
      if (accept) begin
        if (load) begin
          idx_q      <= '0;
          sop_pend_q <= 1'b0;
        end else begin
          idx_q <= idx_q + 1'b1;
          if (state_q == IDLE) sop_pend_q <= 1'b1;
          for (int i = 0; i < RATIO - 1; i++) begin
            if (int'(idx_q) == i) acc_q[i] <= in_data;
          end
        end
      end
    end
  end

`ifdef ST_UPSIZE_PKTLEN_EN
  logic [SAT_W-1:0] len_cnt_q, len_next, pkt_len_q;

  assign len_next = (state_q == IDLE) ? SAT_W'(1) : sat_inc(len_cnt_q);
  assign pkt_len  = pkt_len_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_cnt_q <= '0;
      pkt_len_q <= '0;
    end else if (accept) begin
      len_cnt_q <= len_next;
      if (load && in_eop) pkt_len_q <= len_next;
    end
  end
`endif

  st_out_reg #(
    .W       (OUT_W),
    .EMPTY_W (OUT_EMPTY_W)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .d_data    (wide),
    .d_sop     (wide_sop),
    .d_eop     (in_eop),
    .d_empty   (wide_empty),
    .free      (free),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_empty (out_empty)
  );

endmodule

// File: doc/st_width_upsizer.md
Name: st_width_upsizer

Overview:
- Parametrised Avalon-ST width upsizer. Packs RATIO narrow input beats into one wide output beat, filling most-significant lanes first.
- Accepts packets of any narrow-beat length, including lengths that are not a multiple of RATIO and narrow beats with nonzero empty. Output empty is computed exactly.
- Output side is fully registered, so out_ready never feeds combinationally into in_ready beyond a single mux.
- Sits between narrow sensor/ADC stream sources and the 32/64-bit DMA/FIFO fabric in sensor_algo_qsys.

Parameters:
- SYM_W, 8, bits per symbol.
- IN_SYMS, 2, symbols per input beat (IN_W = SYM_W*IN_SYMS).
- RATIO, 2, input beats per output beat, >= 2 (OUT_W = IN_W*RATIO).
- IN_EMPTY_W, 1, in_empty width, >= clog2(IN_SYMS), minimum 1.
- OUT_EMPTY_W, 2, out_empty width, >= clog2(IN_SYMS*RATIO).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- in_data  in  IN_W  sink data
- in_valid  in  1  sink valid
- in_ready  out  1  sink ready (ready latency 0)
- in_sop  in  1  startofpacket
- in_eop  in  1  endofpacket
- in_empty  in  IN_EMPTY_W  empty symbols; meaningful only with in_eop
- out_data  out  OUT_W  source data
- out_valid  out  1  source valid
- out_ready  in  1  source ready (ready latency 0)
- out_sop  out  1  startofpacket
- out_eop  out  1  endofpacket
- out_empty  out  OUT_EMPTY_W  empty symbols
- drop_cnt  out  16  saturating count of narrow beats discarded outside a packet

Behaviour:
- Reset, asynchronous: out_valid/out_sop/out_eop=0, out_data=0, out_empty=0, drop_cnt=0, state=IDLE, lane index=0, output register empty.
- An input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Storage: accumulator (RATIO-1 lanes), lane index idx in 0..RATIO-1, one wide output register.
- in_ready = !(out_valid && !out_ready) || !closing_beat.
  - closing_beat = (idx==RATIO-1) || in_eop.
  - Non-closing beats are always accepted into the accumulator.
- Lane placement: the beat at idx goes to out bits [OUT_W-1-idx*IN_W -: IN_W].
- FSM, state IDLE:
  - A beat with sop is written at lane 0, sop_pending is set, and the state moves to PKT.
  - If that beat also has eop, it closes immediately.
  - A beat without sop is accepted, discarded, and drop_cnt increments (saturating at 0xFFFF).
- FSM, state PKT:
  - Beats fill consecutive lanes.
  - An sop seen mid-packet is ignored (treated as data).
- Closing beat:
  - The output register loads the accumulator plus the current beat.
  - Unfilled lanes are zero.
  - out_sop = sop_pending, which then clears.
  - out_eop = in_eop.
  - out_empty = (RATIO-1-idx)*IN_SYMS + (in_eop ? in_empty : 0).
  - idx returns to 0. The state returns to IDLE on eop, otherwise stays in PKT.
- Latency: out_valid rises on the cycle after the closing beat's transfer.
- Throughput: one wide beat per RATIO input cycles. A closing beat and an output transfer in the same cycle are legal, giving back-to-back output with no bubble.
- Backpressure: out_valid and out_* stay stable until out_ready.
- Boundary cases:
  - sop+eop single beat: out_empty = (RATIO-1)*IN_SYMS + in_empty.
  - Packet length an exact multiple of RATIO: last output has empty = in_empty.
  - Narrow in_empty is ignored on non-eop beats.
  - drop_cnt does not wrap.
  - Reset mid-packet discards the accumulator and the output register with no partial output.

Optional Feature:
- Macro ST_UPSIZE_PKTLEN_EN.
- Defined:
  - Adds output port pkt_len (16 bits): narrow-beat count of the last completed packet, including sop and eop beats.
  - pkt_len updates on the same cycle out_eop is loaded into the output register and is stable until the next load.
  - Reset value 0. Saturates at 0xFFFF.
- Undefined: port and counter are absent. All other behaviour is identical.

Decomposition:
- Package st_pkg holds:
  - state typedef (IDLE, PKT)
  - lane-offset/empty-calc constant functions
  - saturating-increment width constant
- One natural sub-module, st_out_reg: the single-slot registered Avalon-ST output stage with valid/ready hold. It is reusable by the future downsizer.

Test Plan:
- Defaults, 4-beat packet 0x1111,0x2222,0x3333,0x4444 with sop on first and eop+empty=0 on last, out_ready=1 -> 0x11112222 (sop,empty=0) then 0x33334444 (eop,empty=0). Each appears 1 cycle after its second input beat.
- 3-beat packet 0xAAAA,0xBBBB,0xCCCC with eop empty=1 -> 0xAAAABBBB sop, then 0xCCCC0000 eop with out_empty=3.
- Single beat 0x5A5A with sop+eop, empty=0 -> 0x5A5A0000, sop=eop=1, out_empty=2.
- Hold out_ready=0 for 5 cycles during a 6-beat packet -> in_ready=0 only on closing beats, outputs held stable, no data lost, final order correct.
- 3 beats without sop, then a valid packet -> drop_cnt=3; packet output is unaffected.
- RATIO=4, IN_SYMS=1 (8->32), 5-beat packet 01..05 -> 0x01020304, then 0x05000000 with out_empty=3. Assert rst mid-second-word -> outputs 0, the next packet starts clean.
